// File: rtl/key_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, keycode width and default timing.
// Repeat timing defaults exist only when KEY_REPEAT_EN is defined.
package key_scan_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  localparam int         KEYCODE_W     = 5;
  localparam logic [3:0] ROW_IDLE      = 4'b1110;

  localparam int         CLK_HZ_DEF    = 25_000_000;
  localparam int         SCAN_DIV_DEF  = 25_000;
  localparam int         DEB_TICKS_DEF = 20;
`ifdef KEY_REPEAT_EN
  localparam int         REP_DELAY_DEF = 500;
  localparam int         REP_RATE_DEF  = 100;
`endif

  // Active-low one-hot row drive moves to the next row: 1110 -> 1101 -> 1011 -> 0111.
  function automatic logic [3:0] rotl_row(input logic [3:0] r);
    return {r[2:0], r[3]};
  endfunction

endpackage

// File: rtl/key_tick_gen.sv
// Scan tick divider: one-clk tick every SCAN_DIV clocks, counter wraps SCAN_DIV-1 -> 0.
module key_tick_gen
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int               CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: row drive, column sync, press/release debounce, keycode + key_ready strobe.
// Define KEY_REPEAT_EN to add auto-repeat strobes (keycode[4]=1) while a key is held.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEF,
  parameter int SCAN_DIV  = SCAN_DIV_DEF,
  parameter int DEB_TICKS = DEB_TICKS_DEF
`ifdef KEY_REPEAT_EN
  ,
  parameter int REP_DELAY = REP_DELAY_DEF,
  parameter int REP_RATE  = REP_RATE_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           col_n,
  output logic [3:0]           row_n,
  output logic [KEYCODE_W-1:0] keycode,
  output logic                 key_ready,
  output logic                 key_down
);

  // A zero divider falls back to a 1 ms scan tick derived from the clock rate.
  localparam int               DIV     = (SCAN_DIV > 0) ? SCAN_DIV : CLK_HZ / 1000;
  localparam int               DEB_W   = $clog2(DEB_TICKS + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_TICKS);

  function automatic logic [DEB_W-1:0] deb_inc(input logic [DEB_W-1:0] v);
    return (v == DEB_MAX) ? v : v + 1'b1;
  endfunction

  logic tick;

  key_tick_gen #(.SCAN_DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Stage p0/p1: two-flop synchroniser on the asynchronous column inputs
  logic [3:0] col_p0, col_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= 4'hF;
      col_p1 <= 4'hF;
    end else begin
      col_p0 <= col_n;
      col_p1 <= col_p0;
    end
  end

  logic [3:0] col_low;
  logic       any_low;
  logic [1:0] first_col;

  assign col_low = ~col_p1;
  assign any_low = |col_low;

  always_comb begin
    first_col = 2'd0;
    for (int c = 3; c >= 0; c--)
      if (col_low[c]) first_col = 2'(c);
  end

`ifdef KEY_REPEAT_EN
  localparam int               REP_MAXV  = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int               REP_W     = $clog2(REP_MAXV + 1);
  localparam logic [REP_W-1:0] REP_TOP   = REP_W'(REP_MAXV);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REP_DELAY);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REP_RATE);

  function automatic logic [REP_W-1:0] rep_inc(input logic [REP_W-1:0] v);
    return (v == REP_TOP) ? v : v + 1'b1;
  endfunction

  logic [REP_W-1:0] rep_cnt, rep_nxt;
  logic             rep_armed, armed_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else begin
      rep_cnt   <= rep_nxt;
      rep_armed <= armed_nxt;
    end
  end
`endif

  scan_state_t          state, state_nxt;
  logic [3:0]           row_nxt;
  logic [1:0]           row_idx, row_idx_nxt;
  logic [1:0]           cand_col, cand_col_nxt;
  logic [DEB_W-1:0]     deb_cnt, deb_nxt;
  logic [DEB_W-1:0]     rel_cnt, rel_nxt;
  logic [KEYCODE_W-1:0] code_nxt;
  logic                 ready_nxt, down_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SCAN;
      row_n     <= ROW_IDLE;
      row_idx   <= 2'd0;
      cand_col  <= 2'd0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      keycode   <= '0;
      key_ready <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_n     <= row_nxt;
      row_idx   <= row_idx_nxt;
      cand_col  <= cand_col_nxt;
      deb_cnt   <= deb_nxt;
      rel_cnt   <= rel_nxt;
      keycode   <= code_nxt;
      key_ready <= ready_nxt;
      key_down  <= down_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    row_nxt      = row_n;
    row_idx_nxt  = row_idx;
    cand_col_nxt = cand_col;
    deb_nxt      = deb_cnt;
    rel_nxt      = rel_cnt;
    code_nxt     = keycode;
    ready_nxt    = 1'b0;
    down_nxt     = key_down;
`ifdef KEY_REPEAT_EN
    rep_nxt      = rep_cnt;
    armed_nxt    = rep_armed;
`endif
    if (tick) begin
      unique case (state)
        ST_SCAN: begin
          if (any_low) begin
            cand_col_nxt = first_col;
            deb_nxt      = DEB_W'(1);
            state_nxt    = ST_DEBOUNCE;
          end else begin
            row_nxt     = rotl_row(row_n);
            row_idx_nxt = row_idx + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          // Any other column low on the frozen row aborts the debounce.
          if (col_low == (4'b0001 << cand_col)) begin
            deb_nxt = deb_inc(deb_cnt);
            if (deb_inc(deb_cnt) == DEB_MAX) begin
              code_nxt  = {1'b0, row_idx, cand_col};
              ready_nxt = 1'b1;
              down_nxt  = 1'b1;
              state_nxt = ST_HELD;
`ifdef KEY_REPEAT_EN
              rep_nxt   = '0;
              armed_nxt = 1'b0;
`endif
            end
          end else begin
            deb_nxt     = '0;
            row_nxt     = rotl_row(row_n);
            row_idx_nxt = row_idx + 1'b1;
            state_nxt   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (!any_low) begin
            rel_nxt   = DEB_W'(1);
            state_nxt = ST_RELEASE;
          end
`ifdef KEY_REPEAT_EN
          else begin
            rep_nxt = rep_inc(rep_cnt);
            if (rep_inc(rep_cnt) == (rep_armed ? REP_NEXT : REP_FIRST)) begin
              code_nxt  = {1'b1, row_idx, cand_col};
              ready_nxt = 1'b1;
              rep_nxt   = '0;
              armed_nxt = 1'b1;
            end
          end
`endif
        end
        ST_RELEASE: begin
          if (!any_low) begin
            rel_nxt = deb_inc(rel_cnt);
            if (deb_inc(rel_cnt) == DEB_MAX) begin
              down_nxt    = 1'b0;
              row_nxt     = rotl_row(row_n);
              row_idx_nxt = row_idx + 1'b1;
              state_nxt   = ST_SCAN;
            end
          end else begin
            state_nxt = ST_HELD;
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan: keypad matrix model, tick-level reference model, directed + random presses.
// Build with KEY_REPEAT_EN defined to exercise auto-repeat instead of the long single-strobe hold.
module tb_key_scan;

  localparam int SCAN_DIV = 25;
  localparam int DEB      = 20;
  localparam int CHK_PH   = 12;
`ifdef KEY_REPEAT_EN
  localparam int REP_DELAY = 500;
  localparam int REP_RATE  = 100;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [4:0]  keycode;
  logic        key_ready;
  logic        key_down;
  logic [15:0] keys = '0;

  key_scan #(.CLK_HZ(25_000_000), .SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .keycode   (keycode),
    .key_ready (key_ready),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Pressed key at (r,c) shorts row r to column c; pull-ups keep idle columns high.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, stepped once per scan tick from the keypad contents.
  int         pcnt = 0;
  int         m_row, m_cand, m_stable, m_quiet, m_hold, m_nrep;
  bit         m_held, m_down;
  logic [4:0] m_code;
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  logic [4:0] log_q[$];
  bit         prev_ready = 1'b0;

  task automatic model_reset();
    m_row = 0; m_cand = -1; m_stable = 0; m_quiet = 0; m_hold = 0; m_nrep = 0;
    m_held = 1'b0; m_down = 1'b0; m_code = '0;
    exp_q.delete();
  endtask

  task automatic model_tick();
    logic [3:0] low;
    int first;
    for (int c = 0; c < 4; c++) low[c] = keys[m_row*4+c];
    first = -1;
    for (int c = 3; c >= 0; c--) if (low[c]) first = c;
    if (!m_held) begin
      if (m_cand < 0) begin
        if (first >= 0) begin m_cand = first; m_stable = 1; end
        else m_row = (m_row + 1) % 4;
      end else if (low == (4'b0001 << m_cand)) begin
        m_stable++;
        if (m_stable == DEB) begin
          m_code = 5'(m_row*4 + m_cand);
          exp_q.push_back(m_code);
          m_held = 1'b1; m_down = 1'b1; m_quiet = 0; m_hold = 0; m_nrep = 0;
        end
      end else begin
        m_cand = -1;
        m_row  = (m_row + 1) % 4;
      end
    end else if (low == 4'b0000) begin
      m_quiet++;
      if (m_quiet == DEB) begin
        m_held = 1'b0; m_down = 1'b0; m_cand = -1;
        m_row  = (m_row + 1) % 4;
      end
    end else if (m_quiet > 0) begin
      m_quiet = 0;
    end else begin
`ifdef KEY_REPEAT_EN
      m_hold++;
      if (m_hold == ((m_nrep == 0) ? REP_DELAY : REP_RATE)) begin
        m_code = 5'(16 + m_row*4 + m_cand);
        exp_q.push_back(m_code);
        m_hold = 0;
        m_nrep++;
      end
`endif
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt = 0;
      model_reset();
    end else if (pcnt == SCAN_DIV - 1) begin
      pcnt = 0;
      model_tick();
    end else begin
      pcnt++;
    end
  end

  // Strobe monitor plus once-per-tick comparison against the model.
  always @(negedge clk) begin
    logic [3:0] exp_row;
    if (!rst_n) begin
      chk("rst_ready", key_ready, 1'b0);
      obs_q.delete();
      prev_ready = 1'b0;
    end else begin
      if (key_ready) begin
        chk("ready_gap", prev_ready, 1'b0);
        obs_q.push_back(keycode);
        log_q.push_back(keycode);
      end
      prev_ready = key_ready;
      if (pcnt == CHK_PH) begin
        chk("n_strobes", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
          chk("strobe_code", obs_q[i], exp_q[i]);
        exp_row = ~(4'b0001 << m_row);
        chk("keycode", keycode, m_code);
        chk("key_down", key_down, m_down);
        chk("row_n", row_n, exp_row);
        obs_q.delete();
        exp_q.delete();
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk iff (rst_n && pcnt == CHK_PH));
  endtask

  function automatic logic [7:0] code_at(input int idx);
    return (idx < log_q.size()) ? {3'b000, log_q[idx]} : 8'hFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, t, k1, hold, gap, nb;
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    chk("rst_row_n", row_n, 4'b1110);
    chk("rst_keycode", keycode, 5'h00);
    chk("rst_key_ready", key_ready, 1'b0);
    chk("rst_key_down", key_down, 1'b0);
    rst_n = 1'b1;
    ticks(5);

    // Single press r2c1; the scan may need up to 3 extra ticks to reach row 2.
    s0 = log_q.size();
    keys[2*4+1] = 1'b1;
    t = 0;
    while (!key_down && t < 40) begin ticks(1); t++; end
    chk("t1_latency_ok", (t >= DEB && t <= DEB + 3), 1'b1);
    if (t < 30) ticks(30 - t);
    chk("t1_strobes", log_q.size() - s0, 1);
    chk("t1_code", code_at(s0), 8'h09);
    chk("t1_down", key_down, 1'b1);
    keys = '0;
    ticks(DEB + 5);
    chk("t1_released", key_down, 1'b0);

    // Bouncing r0c3: never stable long enough.
    s0 = log_q.size();
    for (int i = 0; i < 3; i++) begin
      keys[3] = 1'b1; ticks(3);
      keys[3] = 1'b0; ticks(2);
    end
    ticks(DEB + 5);
    chk("t2_strobes", log_q.size() - s0, 0);
    chk("t2_down", key_down, 1'b0);

`ifdef KEY_REPEAT_EN
    // Long hold r2c1 with auto-repeat.
    s0 = log_q.size();
    keys[2*4+1] = 1'b1;
    ticks(1000);
    chk("t6_strobes", log_q.size() - s0, 6);
    chk("t6_first", code_at(s0), 8'h09);
    for (int i = 1; i <= 5; i++) chk("t6_repeat", code_at(s0 + i), 8'h19);
    keys = '0;
    ticks(DEB + 5);
    chk("t6_released", key_down, 1'b0);
`else
    // Long hold r1c2: exactly one strobe, key_down falls DEB ticks after release.
    s0 = log_q.size();
    keys[1*4+2] = 1'b1;
    ticks(1000);
    chk("t3_strobes", log_q.size() - s0, 1);
    chk("t3_code", code_at(s0), 8'h06);
    chk("t3_down", key_down, 1'b1);
    keys = '0;
    ticks(DEB - 1);
    chk("t3_down_held", key_down, 1'b1);
    ticks(1);
    chk("t3_down_fall", key_down, 1'b0);
`endif

    // Two keys: r3c0 first, r1c1 added during debounce.
    s0 = log_q.size();
    keys[3*4+0] = 1'b1;
    ticks(5);
    keys[1*4+1] = 1'b1;
    ticks(40);
    chk("t4_strobes", log_q.size() - s0, 1);
    chk("t4_code", code_at(s0), 8'h0C);
    keys = '0;
    ticks(DEB + 10);
    chk("t4_after", log_q.size() - s0, 1);
    chk("t4_down", key_down, 1'b0);

    // Reset in the middle of a debounce.
    s0 = log_q.size();
    keys[1*4+3] = 1'b1;
    ticks(12);
    rst_n = 1'b0;
    #1;
    chk("t5_row_n", row_n, 4'b1110);
    chk("t5_keycode", keycode, 5'h00);
    chk("t5_key_ready", key_ready, 1'b0);
    chk("t5_key_down", key_down, 1'b0);
    keys = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ticks(DEB + 10);
    chk("t5_strobes", log_q.size() - s0, 0);

    // Random presses, extra keys, bounces and short release glitches.
    for (int ep = 0; ep < 10; ep++) begin
      k1   = $urandom_range(0, 15);
      hold = $urandom_range(1, 35);
      gap  = $urandom_range(0, 25);
      keys = '0;
      keys[k1] = 1'b1;
      if ($urandom_range(0, 2) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin keys[k1] = ~keys[k1]; ticks(1); end
        keys[k1] = 1'b1;
      end
      ticks(hold);
      if ($urandom_range(0, 2) == 0) begin
        keys[k1] = 1'b0;
        ticks($urandom_range(1, 5));
        keys[k1] = 1'b1;
        ticks($urandom_range(5, 25));
      end
      keys = '0;
      ticks(gap);
    end
    keys = '0;
    ticks(DEB + 10);
    chk("rand_idle", key_down, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
